// File: rtl/grom_mem_arbiter.sv
// Two-port arbiter in front of one synchronous RAM: round-robin ownership with a
// bounded burst, I/O cycles kept off the write strobe, one-cycle read return.
module grom_mem_arbiter #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic              p0_we,
    input  logic              p0_ioreq,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic              p1_we,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {OWN_IDLE, OWN_P0, OWN_P1} owner_t;

    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

    owner_t      owner_reg, owner_next;
    logic        last_p1_reg, last_p1_next;   // 1 when P1 was the most recent owner
    logic [7:0]  burst_cnt_reg, burst_cnt_next;
    logic        access0, access1, burst_done;
    logic [1:0]  rd_access;
    logic [1:0]  rvalid_reg;
    logic [DATA_W-1:0] rdata_hold_reg [2];

    assign access0    = (owner_reg == OWN_P0) && p0_req;
    assign access1    = (owner_reg == OWN_P1) && p1_req;
    assign burst_done = (burst_cnt_reg >= BURST_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_reg     <= OWN_IDLE;
            last_p1_reg   <= 1'b1;
            burst_cnt_reg <= 8'd0;
        end else begin
            owner_reg     <= owner_next;
            last_p1_reg   <= last_p1_next;
            burst_cnt_reg <= burst_cnt_next;
        end
    end

    // The counter saturates at the last burst slot, so an uncontested owner is
    // handed off the moment the other port shows up.
    always_comb begin
        owner_next     = owner_reg;
        last_p1_next   = last_p1_reg;
        burst_cnt_next = burst_cnt_reg;
        case (owner_reg)
            OWN_IDLE: begin
                if (p0_req && (!p1_req || last_p1_reg)) begin
                    owner_next     = OWN_P0;
                    burst_cnt_next = 8'd0;
                end else if (p1_req) begin
                    owner_next     = OWN_P1;
                    burst_cnt_next = 8'd0;
                end
            end
            OWN_P0: begin
                if (p0_req && (!p1_req || !burst_done)) begin
                    if (!burst_done) burst_cnt_next = burst_cnt_reg + 8'd1;
                end else begin
                    owner_next     = p1_req ? OWN_P1 : OWN_IDLE;
                    last_p1_next   = 1'b0;
                    burst_cnt_next = 8'd0;
                end
            end
            OWN_P1: begin
                if (p1_req && (!p0_req || !burst_done)) begin
                    if (!burst_done) burst_cnt_next = burst_cnt_reg + 8'd1;
                end else begin
                    owner_next     = p0_req ? OWN_P0 : OWN_IDLE;
                    last_p1_next   = 1'b1;
                    burst_cnt_next = 8'd0;
                end
            end
            default: begin
                owner_next     = OWN_IDLE;
                burst_cnt_next = 8'd0;
            end
        endcase
    end

    assign p0_gnt = (owner_reg == OWN_P0);
    assign p1_gnt = (owner_reg == OWN_P1);

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (access0) begin
            mem_addr  = p0_addr;
            mem_wdata = p0_wdata;
            mem_we    = p0_we && !p0_ioreq;
        end else if (access1) begin
            mem_addr  = p1_addr;
            mem_wdata = p1_wdata;
            mem_we    = p1_we;
        end
    end

    // Only true memory reads get a return slot; I/O cycles and writes do not.
    assign rd_access = {access1 && !p1_we, access0 && !p0_we && !p0_ioreq};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    rvalid_reg[gi]     <= 1'b0;
                    rdata_hold_reg[gi] <= '0;
                end else begin
                    rvalid_reg[gi] <= rd_access[gi];
                    if (rvalid_reg[gi]) rdata_hold_reg[gi] <= mem_rdata;
                end
            end
        end
    endgenerate

    assign p0_rvalid = rvalid_reg[0];
    assign p1_rvalid = rvalid_reg[1];
    assign p0_rdata  = rvalid_reg[0] ? mem_rdata : rdata_hold_reg[0];
    assign p1_rdata  = rvalid_reg[1] ? mem_rdata : rdata_hold_reg[1];

endmodule

// File: tb/tb_grom_mem_arbiter.sv
// Bench for grom_mem_arbiter: two instances (MAX_BURST 4 and 2), each with its own RAM,
// directed vector table, hand sequences and a randomized run against a behavioural model.
module tb_grom_mem_arbiter;
    localparam int AW = 12;
    localparam int DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rst_n;
    logic [1:0] p0_req, p0_we, p0_ioreq, p0_gnt, p0_rvalid;
    logic [1:0] p1_req, p1_we, p1_gnt, p1_rvalid, mem_we;
    logic [1:0][AW-1:0] p0_addr, p1_addr, mem_addr;
    logic [1:0][DW-1:0] p0_wdata, p0_rdata, p1_wdata, p1_rdata, mem_wdata, mem_rdata;

    logic [DW-1:0] ram [2][4096];
    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;

    int errors = 0;
    int checks = 0;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            grom_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(gi == 0 ? 4 : 2)) dut (
                .clk(clk), .reset(rst_n[gi]),
                .p0_req(p0_req[gi]), .p0_addr(p0_addr[gi]), .p0_wdata(p0_wdata[gi]),
                .p0_we(p0_we[gi]), .p0_ioreq(p0_ioreq[gi]), .p0_gnt(p0_gnt[gi]),
                .p0_rvalid(p0_rvalid[gi]), .p0_rdata(p0_rdata[gi]),
                .p1_req(p1_req[gi]), .p1_addr(p1_addr[gi]), .p1_wdata(p1_wdata[gi]),
                .p1_we(p1_we[gi]), .p1_gnt(p1_gnt[gi]),
                .p1_rvalid(p1_rvalid[gi]), .p1_rdata(p1_rdata[gi]),
                .mem_addr(mem_addr[gi]), .mem_wdata(mem_wdata[gi]), .mem_we(mem_we[gi]),
                .mem_rdata(mem_rdata[gi]));
        end
    endgenerate

    // Synchronous RAMs with registered read, plus a preload port.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (ld_en) ram[d][ld_addr] <= ld_data;
            else if (mem_we[d]) ram[d][mem_addr[d]] <= mem_wdata[d];
            mem_rdata[d] <= ram[d][mem_addr[d]];
        end
    end

    function automatic logic [7:0] pattern(int a);
        return (a == 16) ? 8'h5A : 8'((a * 37 + 11) % 256);
    endfunction

    function automatic int mb(int d);
        return (d == 0) ? 4 : 2;
    endfunction

    task automatic chk(string name, int d, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t actual=%0h required=%0h", name, d, $time, act, exp);
        end
    endtask

    // Behavioural model: owner 0=none 1=P0 2=P1, run = granted cycles so far in this tenure.
    int          m_owner [2];
    int          m_last  [2];
    int          m_run   [2];
    bit          m_pend0 [2], m_pend1 [2], m_acc0 [2], m_acc1 [2];
    logic [7:0]  m_pd0 [2], m_pd1 [2], m_hold0 [2], m_hold1 [2];
    logic [7:0]  mmem [2][4096];

    task automatic model_reset(int d);
        m_owner[d] = 0; m_last[d] = 2; m_run[d] = 0;
        m_pend0[d] = 0; m_pend1[d] = 0; m_acc0[d] = 0; m_acc1[d] = 0;
        m_hold0[d] = 0; m_hold1[d] = 0;
    endtask

    task automatic model_cmp();
        for (int d = 0; d < 2; d++) begin
            bit a0, a1, ewe;
            logic [AW-1:0] ea;
            if (!rst_n[d]) model_reset(d);
            a0  = (m_owner[d] == 1) && p0_req[d];
            a1  = (m_owner[d] == 2) && p1_req[d];
            ewe = (a0 && p0_we[d] && !p0_ioreq[d]) || (a1 && p1_we[d]);
            ea  = a0 ? p0_addr[d] : (a1 ? p1_addr[d] : '0);
            chk("m_gnt0", d, p0_gnt[d], m_owner[d] == 1);
            chk("m_gnt1", d, p1_gnt[d], m_owner[d] == 2);
            chk("m_rvalid0", d, p0_rvalid[d], m_pend0[d]);
            chk("m_rvalid1", d, p1_rvalid[d], m_pend1[d]);
            chk("m_rdata0", d, p0_rdata[d], m_pend0[d] ? m_pd0[d] : m_hold0[d]);
            chk("m_rdata1", d, p1_rdata[d], m_pend1[d] ? m_pd1[d] : m_hold1[d]);
            chk("m_mem_we", d, mem_we[d], ewe);
            chk("m_mem_addr", d, mem_addr[d], ea);
            if (ewe) chk("m_mem_wdata", d, mem_wdata[d], a0 ? p0_wdata[d] : p1_wdata[d]);
        end
    endtask

    task automatic model_upd();
        for (int d = 0; d < 2; d++) begin
            bit a0, a1, r0, r1, rm, ro;
            if (!rst_n[d]) begin
                model_reset(d);
                continue;
            end
            r0 = p0_req[d]; r1 = p1_req[d];
            a0 = (m_owner[d] == 1) && r0;
            a1 = (m_owner[d] == 2) && r1;
            if (m_pend0[d]) m_hold0[d] = m_pd0[d];
            if (m_pend1[d]) m_hold1[d] = m_pd1[d];
            m_pend0[d] = a0 && !p0_we[d] && !p0_ioreq[d];
            m_pend1[d] = a1 && !p1_we[d];
            if (m_pend0[d]) m_pd0[d] = mmem[d][p0_addr[d]];
            if (m_pend1[d]) m_pd1[d] = mmem[d][p1_addr[d]];
            if (a0 && p0_we[d] && !p0_ioreq[d]) mmem[d][p0_addr[d]] = p0_wdata[d];
            if (a1 && p1_we[d]) mmem[d][p1_addr[d]] = p1_wdata[d];
            m_acc0[d] = a0; m_acc1[d] = a1;
            if (m_owner[d] == 0) begin
                if (r0 && (!r1 || m_last[d] == 2)) begin m_owner[d] = 1; m_run[d] = 1; end
                else if (r1) begin m_owner[d] = 2; m_run[d] = 1; end
            end else begin
                rm = (m_owner[d] == 1) ? r0 : r1;
                ro = (m_owner[d] == 1) ? r1 : r0;
                if (rm && (!ro || m_run[d] < mb(d))) m_run[d]++;
                else begin
                    m_last[d]  = m_owner[d];
                    m_owner[d] = ro ? 3 - m_owner[d] : 0;
                    m_run[d]   = ro ? 1 : 0;
                end
            end
        end
    endtask

    task automatic half();
        @(negedge clk);
        model_cmp();
    endtask

    task automatic adv();
        @(posedge clk);
        model_upd();
        #1;
    endtask

    task automatic set_p0(int d, bit r, int a, bit we, int wd, bit io);
        p0_req[d] = r; p0_addr[d] = AW'(a); p0_we[d] = we; p0_wdata[d] = DW'(wd); p0_ioreq[d] = io;
    endtask

    task automatic set_p1(int d, bit r, int a, bit we, int wd);
        p1_req[d] = r; p1_addr[d] = AW'(a); p1_we[d] = we; p1_wdata[d] = DW'(wd);
    endtask

    typedef struct {
        bit         r0;
        int         a0;
        bit         we0;
        int         wd0;
        bit         io0;
        bit         g0;
        bit         rv0;
        logic [7:0] rd0;
        bit         mwe;
        logic [11:0] maddr;
    } vec_t;

    vec_t vecs [17];

    initial begin
        // P0 read of 0x010, I/O write (no effect), real write, read-back on instance 0.
        vecs[0]  = '{1, 'h010, 0, 'h00, 0,  0, 0, 8'h00, 0, 12'h000};
        vecs[1]  = '{1, 'h010, 0, 'h00, 0,  1, 0, 8'h00, 0, 12'h010};
        vecs[2]  = '{0, 'h000, 0, 'h00, 0,  1, 1, 8'h5A, 0, 12'h000};
        vecs[3]  = '{0, 'h000, 0, 'h00, 0,  0, 0, 8'h5A, 0, 12'h000};
        vecs[4]  = '{1, 'h020, 1, 'hFF, 1,  0, 0, 8'h5A, 0, 12'h000};
        vecs[5]  = '{1, 'h020, 1, 'hFF, 1,  1, 0, 8'h5A, 0, 12'h020};
        vecs[6]  = '{0, 'h000, 0, 'h00, 0,  1, 0, 8'h5A, 0, 12'h000};
        vecs[7]  = '{1, 'h020, 0, 'h00, 0,  0, 0, 8'h5A, 0, 12'h000};
        vecs[8]  = '{1, 'h020, 0, 'h00, 0,  1, 0, 8'h5A, 0, 12'h020};
        vecs[9]  = '{0, 'h000, 0, 'h00, 0,  1, 1, 8'hAB, 0, 12'h000};
        vecs[10] = '{1, 'h020, 1, 'hFF, 0,  0, 0, 8'hAB, 0, 12'h000};
        vecs[11] = '{1, 'h020, 1, 'hFF, 0,  1, 0, 8'hAB, 1, 12'h020};
        vecs[12] = '{0, 'h000, 0, 'h00, 0,  1, 0, 8'hAB, 0, 12'h000};
        vecs[13] = '{1, 'h020, 0, 'h00, 0,  0, 0, 8'hAB, 0, 12'h000};
        vecs[14] = '{1, 'h020, 0, 'h00, 0,  1, 0, 8'hAB, 0, 12'h020};
        vecs[15] = '{0, 'h000, 0, 'h00, 0,  1, 1, 8'hFF, 0, 12'h000};
        vecs[16] = '{0, 'h000, 0, 'h00, 0,  0, 0, 8'hFF, 0, 12'h000};

        rst_n = 2'b00;
        for (int d = 0; d < 2; d++) begin
            set_p0(d, 0, 0, 0, 0, 0);
            set_p1(d, 0, 0, 0, 0);
            model_reset(d);
        end
        ld_en = 1'b1;
        for (int a = 0; a < 4096; a++) begin
            ld_addr = AW'(a);
            ld_data = pattern(a);
            mmem[0][a] = pattern(a);
            mmem[1][a] = pattern(a);
            @(posedge clk);
            #1;
        end
        ld_en = 1'b0;

        half();
        for (int d = 0; d < 2; d++) begin
            chk("rst_gnt0", d, p0_gnt[d], 0);
            chk("rst_gnt1", d, p1_gnt[d], 0);
            chk("rst_rvalid", d, {p0_rvalid[d], p1_rvalid[d]}, 0);
            chk("rst_mem_we", d, mem_we[d], 0);
            chk("rst_mem_addr", d, mem_addr[d], 0);
            chk("rst_mem_wdata", d, mem_wdata[d], 0);
        end
        adv();
        rst_n = 2'b11;

        for (int i = 0; i < 17; i++) begin
            set_p0(0, vecs[i].r0, vecs[i].a0, vecs[i].we0, vecs[i].wd0, vecs[i].io0);
            half();
            chk($sformatf("vec%0d_gnt0", i), 0, p0_gnt[0], vecs[i].g0);
            chk($sformatf("vec%0d_gnt1", i), 0, p1_gnt[0], 0);
            chk($sformatf("vec%0d_rvalid0", i), 0, p0_rvalid[0], vecs[i].rv0);
            chk($sformatf("vec%0d_rdata0", i), 0, p0_rdata[0], vecs[i].rd0);
            chk($sformatf("vec%0d_mem_we", i), 0, mem_we[0], vecs[i].mwe);
            chk($sformatf("vec%0d_mem_addr", i), 0, mem_addr[0], vecs[i].maddr);
            adv();
        end

        // Continuous contention after reset: P0 x4, P1 x4, P0 x4, no gaps.
        rst_n[0] = 1'b0;
        set_p0(0, 1, 'h030, 0, 0, 0);
        set_p1(0, 1, 'h040, 0, 0);
        half();
        adv();
        rst_n[0] = 1'b1;
        for (int k = 0; k <= 12; k++) begin
            bit e0, e1;
            e0 = (k >= 1) && (((k - 1) / 4) % 2 == 0);
            e1 = (k >= 1) && !e0;
            half();
            chk($sformatf("rr%0d_gnt0", k), 0, p0_gnt[0], e0);
            chk($sformatf("rr%0d_gnt1", k), 0, p1_gnt[0], e1);
            adv();
        end
        set_p0(0, 0, 0, 0, 0, 0);
        set_p1(0, 0, 0, 0, 0);
        repeat (3) begin half(); adv(); end

        // P1 uncontested write stream, then read-back.
        set_p1(0, 1, 'h100, 1, 'h30);
        half();
        chk("wstream_wait_gnt1", 0, p1_gnt[0], 0);
        adv();
        for (int i = 0; i < 8; i++) begin
            set_p1(0, 1, 'h100 + i, 1, 'h30 + i);
            half();
            chk($sformatf("wstream%0d_gnt1", i), 0, p1_gnt[0], 1);
            chk($sformatf("wstream%0d_mem_we", i), 0, mem_we[0], 1);
            chk($sformatf("wstream%0d_mem_addr", i), 0, mem_addr[0], 'h100 + i);
            adv();
        end
        set_p1(0, 0, 0, 0, 0);
        repeat (2) begin half(); adv(); end
        set_p1(0, 1, 'h100, 0, 0);
        half();
        adv();
        for (int i = 0; i < 8; i++) begin
            set_p1(0, 1, 'h100 + i, 0, 0);
            half();
            chk($sformatf("rstream%0d_gnt1", i), 0, p1_gnt[0], 1);
            if (i > 0) begin
                chk($sformatf("rstream%0d_rvalid1", i), 0, p1_rvalid[0], 1);
                chk($sformatf("rstream%0d_rdata1", i), 0, p1_rdata[0], 'h30 + i - 1);
            end
            adv();
        end
        set_p1(0, 0, 0, 0, 0);
        half();
        chk("rstream_last_rvalid1", 0, p1_rvalid[0], 1);
        chk("rstream_last_rdata1", 0, p1_rdata[0], 'h37);
        adv();
        repeat (2) begin half(); adv(); end

        // MAX_BURST=2 instance: P0 arrives at burst_cnt=1 and takes the bus next edge.
        set_p1(1, 1, 'h200, 0, 0);
        half(); adv();
        half();
        chk("pre_gnt1_first", 1, p1_gnt[1], 1);
        adv();
        set_p1(1, 1, 'h201, 0, 0);
        set_p0(1, 1, 'h300, 0, 0, 0);
        half();
        chk("pre_gnt1_second", 1, p1_gnt[1], 1);
        chk("pre_gnt0_wait", 1, p0_gnt[1], 0);
        adv();
        set_p1(1, 1, 'h202, 0, 0);
        half();
        chk("pre_switch_gnt0", 1, p0_gnt[1], 1);
        chk("pre_switch_gnt1", 1, p1_gnt[1], 0);
        chk("pre_inflight_rvalid1", 1, p1_rvalid[1], 1);
        chk("pre_inflight_rdata1", 1, p1_rdata[1], pattern('h201));
        adv();
        set_p0(1, 0, 0, 0, 0, 0);
        repeat (3) begin half(); adv(); end
        set_p1(1, 0, 0, 0, 0);
        repeat (3) begin half(); adv(); end

        // Reset mid-burst on instance 0 after P0 was the last owner.
        set_p0(0, 1, 'h050, 0, 0, 0);
        half(); adv();
        half(); adv();
        set_p0(0, 0, 0, 0, 0, 0);
        half(); adv();
        set_p0(0, 1, 'h051, 0, 0, 0);
        half(); adv();
        half();
        chk("mid_gnt0", 0, p0_gnt[0], 1);
        adv();
        rst_n[0] = 1'b0;
        half();
        chk("mid_rst_gnt0", 0, p0_gnt[0], 0);
        chk("mid_rst_rvalid0", 0, p0_rvalid[0], 0);
        chk("mid_rst_mem_we", 0, mem_we[0], 0);
        adv();
        half(); adv();
        rst_n[0] = 1'b1;
        set_p0(0, 1, 'h060, 0, 0, 0);
        set_p1(0, 1, 'h070, 0, 0);
        half();
        chk("post_rst_idle", 0, {p0_gnt[0], p1_gnt[0]}, 0);
        adv();
        half();
        chk("post_rst_gnt0", 0, p0_gnt[0], 1);
        chk("post_rst_gnt1", 0, p1_gnt[0], 0);
        adv();

        // Randomized traffic with occasional resets, both instances.
        for (int n = 0; n < 3000; n++) begin
            for (int d = 0; d < 2; d++) begin
                if (!rst_n[d]) rst_n[d] = 1'b1;
                else if ($urandom_range(0, 299) == 0) rst_n[d] = 1'b0;
                if (!p0_req[d] || m_acc0[d])
                    set_p0(d, $urandom_range(0, 99) < 65, 'h400 + $urandom_range(0, 15),
                           $urandom_range(0, 2) == 0, $urandom_range(0, 255),
                           $urandom_range(0, 5) == 0);
                if (!p1_req[d] || m_acc1[d])
                    set_p1(d, $urandom_range(0, 99) < 65, 'h400 + $urandom_range(0, 15),
                           $urandom_range(0, 2) == 0, $urandom_range(0, 255));
            end
            half();
            chk("rand_onehot", 0, p0_gnt[0] & p1_gnt[0], 0);
            chk("rand_onehot", 1, p0_gnt[1] & p1_gnt[1], 0);
            adv();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/grom_mem_arbiter.md
Name: grom_mem_arbiter

Overview:
- Shares the single synchronous 8-bit RAM (12-bit address) between two requesters.
- Port 0 is the grom CPU bus. Port 1 is an auxiliary master: boot loader, DMA or video fetch.
- Registered request/grant handshake with round-robin fairness and a bounded burst length.
- Gates CPU I/O cycles off the memory write strobe and returns read data with the RAM's fixed one-cycle latency.

Parameters:
- ADDR_W, 12, address width of ports and memory.
- DATA_W, 8, data width.
- MAX_BURST, 4, maximum consecutive granted cycles for one owner while the other port is requesting. Legal range 1..255.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- p0_req  in  1  CPU requests the bus.
- p0_addr  in  ADDR_W  CPU address.
- p0_wdata  in  DATA_W  CPU write data.
- p0_we  in  1  CPU write enable.
- p0_ioreq  in  1  CPU cycle is I/O, not memory.
- p0_gnt  out  1  CPU owns the bus this cycle.
- p0_rvalid  out  1  p0_rdata valid.
- p0_rdata  out  DATA_W  read data to CPU.
- p1_req, p1_addr, p1_wdata, p1_we, p1_gnt, p1_rvalid, p1_rdata: same as the p0 signals. Port 1 has no ioreq.
- mem_addr  out  ADDR_W  to RAM addr.
- mem_wdata  out  DATA_W  to RAM data_in.
- mem_we  out  1  to RAM we.
- mem_rdata  in  DATA_W  from RAM data_out, valid one cycle after the address.

Behaviour:
- State: owner ∈ {IDLE, P0, P1}; last_owner bit; 8-bit burst_cnt; registered rvalid/route flags.
- Reset (reset=0, asynchronous):
  - owner=IDLE, last_owner=P1 so P0 wins first, burst_cnt=0.
  - All gnt, rvalid and mem_we = 0; mem_addr=0, mem_wdata=0.
  - Reset mid-burst drops any pending rvalid. No write is issued after reset assertion.
- Grants: gnt_x are registered. gnt_x=1 exactly when owner=Px. At most one gnt is high per cycle.
- Access: a cycle with gnt_x=1 and req_x=1 is an access.
  - mem_addr and mem_wdata are combinationally muxed from Px.
  - mem_we = we_x, further ANDed with ~p0_ioreq for P0.
  - When owner=IDLE, or the owner has dropped req: mem_addr=0, mem_we=0.
- Read return:
  - A non-write access in cycle N gives rvalid_x=1 in cycle N+1, with rdata_x = mem_rdata.
  - Writes produce no rvalid.
  - P0 I/O accesses (ioreq=1) produce no rvalid and no mem_we; they still count toward the burst.
  - rdata_x holds its last value when rvalid_x=0.
- Latency: req_x rising in cycle N with the bus idle gives gnt_x in N+1, access in N+1, read data in N+2.
- Next-owner decision, evaluated at every edge:
  - owner=Px, req_x=1, and (other port idle or burst_cnt < MAX_BURST-1): keep Px, burst_cnt+1.
  - owner=Px and other port requesting, with req_x=0 or burst_cnt = MAX_BURST-1: switch directly to the other port. No dead cycle; burst_cnt=0; last_owner=Px.
  - owner=Px, req_x=0, other port idle: go IDLE, last_owner=Px.
  - IDLE, one requester: grant it.
  - IDLE, both requesting: grant the port ≠ last_owner.
- burst_cnt saturates at MAX_BURST-1 while the owner is uncontested; it never wraps.
- MAX_BURST=1 under continuous contention gives strict alternation P0,P1,P0,...
- Requester rule: the requester holds addr/we/wdata stable while req=1. The access completes only in a cycle where its gnt=1; ungranted cycles are stalls.
- Dropping req while granted releases the bus at the next edge. No access is issued in the release cycle.

Test Plan:
- Reset then p0 read, addr 0x010 (RAM holds 0x5A) -> gnt0 at cycle 1, mem_addr=0x010, rvalid0 at cycle 2 with rdata0=0x5A, mem_we never asserted.
- Both req asserted in the same cycle after reset, continuous, MAX_BURST=4 -> grants P0×4, P1×4, P0×4; no cycle with both gnt; no idle cycle between owners.
- p0 write with ioreq=1, addr 0x020, data 0xFF -> mem_we=0, no rvalid0, RAM[0x020] unchanged. Same access with ioreq=0 writes 0xFF; a subsequent read returns 0xFF.
- p1 streams writes to 0x100..0x107 while p0 idle -> p1 keeps the grant all 8 cycles (burst_cnt saturates, no forced switch); RAM contents verified.
- p1 owns the bus, p0 requests at burst_cnt=1, MAX_BURST=2 -> gnt switches to P0 on the next edge. p1's in-flight read still gets rvalid1 with the correct data.
- reset pulled low mid-burst, the cycle after a read access -> rvalid and gnt drop immediately. After release, P0 is granted first when both request.
